// File: rtl/complete_arbiter_pkg.sv
// Shared widths and result record for the FU -> complete-stage arbiter.
package complete_arbiter_pkg;
  localparam int DATA_W = 32;
  localparam int PREG_W = 6;
  localparam int ROB_W  = 4;
  localparam int NUM_FU = 3;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [PREG_W-1:0] dest;
    logic [ROB_W-1:0]  rob;
  } fu_result_t;
endpackage

// File: rtl/result_fifo.sv
// Per-FU result queue: DEPTH entries, registered count, ready = not full.
module result_fifo
  import complete_arbiter_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fu_result_t,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  entry_t           din,
  output entry_t           head,
  output logic [CNT_W-1:0] count,
  output logic             ready
);
  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: count gates everything that reads it.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign ready = (count != CNT_W'(DEPTH));
endmodule

// File: rtl/complete_arbiter.sv
// Queues per-FU results and retires one per cycle, round-robin, onto a registered result bus.
module complete_arbiter #(
  parameter int DATA_W = complete_arbiter_pkg::DATA_W,
  parameter int PREG_W = complete_arbiter_pkg::PREG_W,
  parameter int ROB_W  = complete_arbiter_pkg::ROB_W,
  parameter int NUM_FU = complete_arbiter_pkg::NUM_FU,
  parameter int DEPTH  = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en_flag_i,
  input  logic                           flush_i,
  input  logic [NUM_FU-1:0]              fu_valid_i,
  input  logic [NUM_FU-1:0][DATA_W-1:0]  fu_result_i,
  input  logic [NUM_FU-1:0][PREG_W-1:0]  fu_dest_i,
  input  logic [NUM_FU-1:0][ROB_W-1:0]   fu_rob_i,
  output logic [NUM_FU-1:0]              fu_ready_o,
  output logic [DATA_W-1:0]              result,
  output logic [PREG_W-1:0]              result_dest,
  output logic [ROB_W-1:0]               result_ROB,
  output logic [1:0]                     result_FU,
  output logic                           result_valid,
  output logic                           en_flag_o
);
  localparam int FU_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [PREG_W-1:0] dest;
    logic [ROB_W-1:0]  rob;
  } entry_t;

  entry_t [NUM_FU-1:0]            head;
  logic   [NUM_FU-1:0][CNT_W-1:0] count;
  logic   [NUM_FU-1:0]            push, pop, nonempty;
  logic   [FU_W-1:0]              rr_ptr, gnt_idx;
  logic                           gnt_vld;

  for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
    entry_t din;
    assign din         = '{result: fu_result_i[i], dest: fu_dest_i[i], rob: fu_rob_i[i]};
    assign push[i]     = fu_valid_i[i] & fu_ready_o[i] & ~flush_i;
    assign pop[i]      = gnt_vld & (gnt_idx == FU_W'(i)) & ~flush_i;
    assign nonempty[i] = (count[i] != '0);

    result_fifo #(.DEPTH(DEPTH), .entry_t(entry_t)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush_i),
      .push  (push[i]),
      .pop   (pop[i]),
      .din   (din),
      .head  (head[i]),
      .count (count[i]),
      .ready (fu_ready_o[i])
    );
  end

  // Scan from farthest to nearest so the FU right after rr_ptr wins.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt_idx = rr_ptr;
    if (en_flag_i) begin
      for (int k = NUM_FU; k >= 1; k--) begin
        idx = (int'(rr_ptr) + k) % NUM_FU;
        if (nonempty[idx]) begin
          gnt_vld = 1'b1;
          gnt_idx = FU_W'(idx);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result       <= '0;
      result_dest  <= '0;
      result_ROB   <= '0;
      result_FU    <= '0;
      result_valid <= 1'b0;
      en_flag_o    <= 1'b0;
      rr_ptr       <= FU_W'(NUM_FU - 1);
    end else begin
      en_flag_o <= en_flag_i;
      if (flush_i) begin
        result_valid <= 1'b0;
      end else if (gnt_vld) begin
        result       <= head[gnt_idx].result;
        result_dest  <= head[gnt_idx].dest;
        result_ROB   <= head[gnt_idx].rob;
        result_FU    <= 2'(gnt_idx);
        result_valid <= 1'b1;
        rr_ptr       <= gnt_idx;
      end else begin
        result_valid <= 1'b0;
      end
    end
  end
endmodule
